cycle_profile_ctrl: RTL

Multi-channel cycle-profiling controller for the Unet wrapper. It owns one shared free-running timestamp counter and sequences up to NUM_CH independent start/stop measurement regions (for example per-layer start/done strobes). Each finished measurement becomes an elapsed-cycle result. Results are arbitrated round-robin into a small result FIFO that the host drains over a valid/ready interface.

---
 rtl/cycle_profile_pkg.sv | 22 ++
 rtl/profile_result_fifo.sv | 86 ++++++++
 rtl/cycle_profile_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cycle_profile_pkg.sv
`default_nettype none
// ============================================================================
// cycle_profile_pkg : shared channel-state type and width helpers. Rev 1.0
// ============================================================================
package cycle_profile_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_PEND = 2'd2
  } ch_state_e;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/profile_result_fifo.sv
`default_nettype none
// ============================================================================
// profile_result_fifo : synchronous first-word-fall-through result FIFO. Rev 1.0
// ============================================================================
module profile_result_fifo
  import cycle_profile_pkg::*;
#(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W:0] FULL_CNT = OCC_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = push & ~r_full;
  assign w_pop_ok  = pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + OCC_W'(1);
      2'b01:   w_count_nxt = r_count - OCC_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage carries no reset; the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign pop_data = r_empty ? '0 : r_mem[r_rd_ptr];
  assign full     = r_full;
  assign empty    = r_empty;

endmodule
`default_nettype wire

// File: rtl/cycle_profile_ctrl.sv
`default_nettype none
// ============================================================================
// cycle_profile_ctrl : shared timestamp, per-channel start/stop regions and
// round-robin arbitration of elapsed-cycle results into a FWFT FIFO. Rev 1.0
// ============================================================================
module cycle_profile_ctrl
  import cycle_profile_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [NUM_CH-1:0]             ch_start,
  input  logic [NUM_CH-1:0]             ch_stop,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ch_idx_w(NUM_CH)-1:0]   res_ch,
  output logic [CNT_W-1:0]              res_cycles,
  output logic [NUM_CH-1:0]             busy,
  output logic                          err,
  output logic [CNT_W-1:0]              timestamp
);

  localparam int IDX_W   = ch_idx_w(NUM_CH);
  localparam int ENTRY_W = IDX_W + CNT_W;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  logic [CNT_W-1:0]   r_timestamp;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_err;
  logic [NUM_CH-1:0]  w_pend;
  logic [NUM_CH-1:0]  w_drop;
  logic [NUM_CH-1:0]  w_grant;
  logic [CNT_W-1:0]   w_elapsed [NUM_CH];
  logic               w_grant_vld;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  // ---------------------------------------------------------------------------
  // Shared timestamp, round-robin pointer and sticky drop flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timestamp <= '0;
      r_rr_ptr    <= '0;
      r_err       <= 1'b0;
    end else if (clear) begin
      r_timestamp <= '0;
      r_rr_ptr    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (enable) begin
        r_timestamp <= r_timestamp + CNT_W'(1);
      end
      if (w_grant_vld) begin
        r_rr_ptr <= (w_grant_idx == LAST_CH) ? '0 : w_grant_idx + IDX_W'(1);
      end
      if (|w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel measurement FSMs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_start_ts;
    logic [CNT_W-1:0] r_elapsed;
    logic             r_busy;
    logic             w_start_take;
    logic             w_stop_take;

    // Stop has precedence in RUN simply because start is not looked at there.
    always_comb begin
      w_state_nxt  = r_state;
      w_start_take = 1'b0;
      w_stop_take  = 1'b0;
      case (r_state)
        CH_IDLE: begin
          if (ch_start[i] && enable) begin
            w_state_nxt  = CH_RUN;
            w_start_take = 1'b1;
          end
        end
        CH_RUN: begin
          if (ch_stop[i]) begin
            w_state_nxt = CH_PEND;
            w_stop_take = 1'b1;
          end
        end
        CH_PEND: begin
          if (w_grant[i]) begin
            w_state_nxt = CH_IDLE;
          end
        end
        default: w_state_nxt = CH_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state    <= CH_IDLE;
        r_start_ts <= '0;
        r_elapsed  <= '0;
        r_busy     <= 1'b0;
      end else if (clear) begin
        r_state    <= CH_IDLE;
        r_start_ts <= '0;
        r_elapsed  <= '0;
        r_busy     <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_busy  <= (w_state_nxt != CH_IDLE);
        if (w_start_take) begin
          r_start_ts <= r_timestamp;
        end
        // Modular subtraction keeps the count correct across a counter wrap.
        if (w_stop_take) begin
          r_elapsed <= r_timestamp - r_start_ts;
        end
      end
    end

    assign w_pend[i]    = (r_state == CH_PEND);
    assign w_drop[i]    = (r_state == CH_PEND) && ch_start[i];
    assign w_elapsed[i] = r_elapsed;
    assign busy[i]      = r_busy;
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first PEND channel at or after the pointer
  // ---------------------------------------------------------------------------
  always_comb begin : p_arb
    int j;
    j           = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_CH) begin
        j = j - NUM_CH;
      end
      if (!w_grant_vld && !w_fifo_full && w_pend[IDX_W'(j)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IDX_W'(j);
      end
    end
    if (w_grant_vld) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_push_data = {w_grant_idx, w_elapsed[w_grant_idx]};
  assign w_pop       = ~w_fifo_empty & res_ready;

  profile_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (w_grant_vld),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign res_valid  = ~w_fifo_empty;
  assign res_ch     = w_head[ENTRY_W-1 -: IDX_W];
  assign res_cycles = w_head[CNT_W-1:0];
  assign err        = r_err;
  assign timestamp  = r_timestamp;

endmodule
`default_nettype wire
